// File: rtl/ps2_move_pkg.sv
// rtl/ps2_move_pkg.sv - scan codes, state enums and coordinate decode for PS/2 move entry
package ps2_move_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_BRK,
        PS_EXT,
        PS_EXT_BRK
    } parse_state_t;

    typedef enum logic {
        CS_COLLECT,
        CS_WRITE
    } commit_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] val;
    } coord_t;

    // Letters A..H in scan-code order
    function automatic coord_t file_of(input logic [7:0] code);
        coord_t c;
        c = '0;
        case (code)
            8'h1C: c = '{1'b1, 3'd0};
            8'h32: c = '{1'b1, 3'd1};
            8'h21: c = '{1'b1, 3'd2};
            8'h23: c = '{1'b1, 3'd3};
            8'h24: c = '{1'b1, 3'd4};
            8'h2B: c = '{1'b1, 3'd5};
            8'h34: c = '{1'b1, 3'd6};
            8'h33: c = '{1'b1, 3'd7};
            default: c = '0;
        endcase
        return c;
    endfunction

    // Digits 1..8 in scan-code order
    function automatic coord_t rank_of(input logic [7:0] code);
        coord_t c;
        c = '0;
        case (code)
            8'h16: c = '{1'b1, 3'd0};
            8'h1E: c = '{1'b1, 3'd1};
            8'h26: c = '{1'b1, 3'd2};
            8'h25: c = '{1'b1, 3'd3};
            8'h2E: c = '{1'b1, 3'd4};
            8'h36: c = '{1'b1, 3'd5};
            8'h3D: c = '{1'b1, 3'd6};
            8'h3E: c = '{1'b1, 3'd7};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// rtl/ps2_scan_parser.sv - F0/E0 prefix tracker producing same-cycle make events
module ps2_scan_parser
    import ps2_move_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_pressed,
    output logic       make_strobe,
    output logic [7:0] make_code,
    output logic       make_ext
);

    parse_state_t state, state_nxt;

    assign make_code = key_data;

    // Prefix state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Make events are combinational so actions land on the strobe's own edge
    always_comb begin
        state_nxt   = state;
        make_strobe = 1'b0;
        make_ext    = 1'b0;
        if (key_pressed) begin
            case (state)
                PS_IDLE: begin
                    if (key_data == SC_BREAK) begin
                        state_nxt = PS_BRK;
                    end else if (key_data == SC_EXT) begin
                        state_nxt = PS_EXT;
                    end else begin
                        make_strobe = 1'b1;
                    end
                end
                PS_EXT: begin
                    if (key_data == SC_BREAK) begin
                        state_nxt = PS_EXT_BRK;
                    end else begin
                        make_strobe = 1'b1;
                        make_ext    = 1'b1;
                        state_nxt   = PS_IDLE;
                    end
                end
                default: state_nxt = PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_move_entry.sv
// rtl/ps2_move_entry.sv - collects a board square from PS/2 keys and writes it to a slot word
module ps2_move_entry
    import ps2_move_pkg::*;
#(
    parameter int BOARD_DIM   = 8,
    parameter int NUM_SLOTS   = 2,
    parameter int BASE_ADDR   = 64,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int AUTO_COMMIT = 1,
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        ps2_key_data,
    input  logic              ps2_key_pressed,
    input  logic              wr_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [SLOT_W-1:0] slot_sel,
    output logic              letter_valid,
    output logic              number_valid
);

    localparam logic [3:0]        BD4       = 4'(BOARD_DIM);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    logic          make_strobe;
    logic [7:0]    make_code;
    logic          unused_make_ext;

    commit_state_t state, state_nxt;
    logic [2:0]    file_q, rank_q, nxt_file, nxt_rank;
    logic          nxt_lv, nxt_nv;
    logic [SLOT_W-1:0] nxt_slot;
    coord_t        fc, rc;
    logic          act, commit_now;

    // Arrows behave the same with or without the E0 prefix
    ps2_scan_parser u_parser (
        .clock       (clock),
        .reset       (reset),
        .key_data    (ps2_key_data),
        .key_pressed (ps2_key_pressed),
        .make_strobe (make_strobe),
        .make_code   (make_code),
        .make_ext    (unused_make_ext)
    );

    assign act    = make_strobe && (state == CS_COLLECT);
    assign mem_we = (state == CS_WRITE);

    // Next coordinate/slot values for a make event seen while collecting
    always_comb begin
        nxt_lv   = letter_valid;
        nxt_nv   = number_valid;
        nxt_file = file_q;
        nxt_rank = rank_q;
        nxt_slot = slot_sel;
        fc       = file_of(make_code);
        rc       = rank_of(make_code);
        if (act) begin
            if (fc.hit) begin
                if (4'(fc.val) < BD4) begin
                    nxt_file = fc.val;
                    nxt_lv   = 1'b1;
                end
            end else if (rc.hit) begin
                if (4'(rc.val) < BD4) begin
                    nxt_rank = rc.val;
                    nxt_nv   = 1'b1;
                end
            end else begin
                case (make_code)
                    SC_LEFT:  nxt_slot = (slot_sel == '0) ? SLOT_LAST : slot_sel - 1'b1;
                    SC_RIGHT: nxt_slot = (slot_sel == SLOT_LAST) ? '0 : slot_sel + 1'b1;
                    SC_BKSP: begin
                        if (number_valid) begin
                            nxt_nv = 1'b0;
                        end else begin
                            nxt_lv = 1'b0;
                        end
                    end
                    SC_ESC: begin
                        nxt_lv = 1'b0;
                        nxt_nv = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Auto mode fires on the strobe that completes the pair; manual mode only on Enter
    always_comb begin
        commit_now = 1'b0;
        if (act) begin
            if (AUTO_COMMIT != 0) begin
                commit_now = nxt_lv && nxt_nv;
            end else begin
                commit_now = (make_code == SC_ENTER) && letter_valid && number_valid;
            end
        end
    end

    // Commit FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            CS_COLLECT: if (commit_now) state_nxt = CS_WRITE;
            CS_WRITE:   if (wr_ready)   state_nxt = CS_COLLECT;
            default:    state_nxt = CS_COLLECT;
        endcase
    end

    // Commit FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CS_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Coordinate, slot and write-word registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            letter_valid <= 1'b0;
            number_valid <= 1'b0;
            file_q       <= '0;
            rank_q       <= '0;
            slot_sel     <= '0;
            mem_addr     <= ADDR_W'(BASE_ADDR);
            mem_data     <= '0;
        end else if (state == CS_COLLECT) begin
            letter_valid <= nxt_lv;
            number_valid <= nxt_nv;
            file_q       <= nxt_file;
            rank_q       <= nxt_rank;
            slot_sel     <= nxt_slot;
            if (commit_now) begin
                mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(slot_sel);
                mem_data <= DATA_W'({nxt_rank, nxt_file});
            end
        end else if (wr_ready) begin
            letter_valid <= 1'b0;
            number_valid <= 1'b0;
        end
    end

endmodule
